// File: rtl/vga_box_plot_ctrl_if.sv
// Pixel-port bundle for the box/clear sequencer: request side (origin load, draw, clear)
// and pixel side (x, y, colour, plot strobe, busy, done).
interface vga_box_plot_ctrl_if;
  logic       ld_x;
  logic       ld_y;
  logic [6:0] data_in;
  logic [2:0] colour_in;
  logic       draw;
  logic       clear;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  // master: the sequencer driving the pixel port
  modport master (
    input  ld_x, ld_y, data_in, colour_in, draw, clear,
    output x, y, colour, plot, busy, done
  );

  // slave: the requester / frame-buffer writer side
  modport slave (
    output ld_x, ld_y, data_in, colour_in, draw, clear,
    input  x, y, colour, plot, busy, done
  );
endinterface

// File: rtl/vga_box_plot_ctrl.sv
// Box-draw / screen-clear pixel sequencer: first plot one cycle after the request, one pixel
// per cycle, done the cycle after the last plot; requests and origin loads are dropped while busy.
module vga_box_plot_ctrl #(
  parameter int BOX_W    = 4,
  parameter int BOX_H    = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  vga_box_plot_ctrl_if.master   bus
);

  localparam logic [7:0] BOX_X_LAST = 8'(BOX_W - 1);
  localparam logic [6:0] BOX_Y_LAST = 7'(BOX_H - 1);
  localparam logic [7:0] SCR_X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] SCR_Y_LAST = 7'(SCREEN_H - 1);
  localparam logic [8:0] SCR_W9     = 9'(SCREEN_W);
  localparam logic [7:0] SCR_H8     = 8'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, DRAW, CLEAR, DONE} state_t;

  state_t     state;
  logic [7:0] x_org;
  logic [6:0] y_org;
  logic [7:0] cx;
  logic [6:0] cy;
  logic [2:0] col_r;

  // Sums carry one extra bit so a box hanging off the bottom/right edge clips
  // instead of wrapping back onto the screen.
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       on_screen;

  assign sum_x     = {1'b0, x_org} + {1'b0, cx};
  assign sum_y     = {1'b0, y_org} + {1'b0, cy};
  assign on_screen = (sum_x < SCR_W9) && (sum_y < SCR_H8);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      x_org      <= '0;
      y_org      <= '0;
      cx         <= '0;
      cy         <= '0;
      col_r      <= '0;
      bus.x      <= '0;
      bus.y      <= '0;
      bus.colour <= '0;
      bus.plot   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      bus.plot <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ld_x) x_org <= {1'b0, bus.data_in};
          if (bus.ld_y) y_org <= bus.data_in;
          cx <= '0;
          cy <= '0;
          if (bus.clear) begin
            state    <= CLEAR;
            bus.busy <= 1'b1;
          end else if (bus.draw) begin
            state    <= DRAW;
            col_r    <= bus.colour_in;
            bus.busy <= 1'b1;
          end
        end

        DRAW: begin
          // Clipped pixels use their cycle but leave the pixel outputs untouched.
          if (on_screen) begin
            bus.x      <= sum_x[7:0];
            bus.y      <= sum_y[6:0];
            bus.colour <= col_r;
            bus.plot   <= 1'b1;
          end
          if (cx == BOX_X_LAST) begin
            cx <= '0;
            if (cy == BOX_Y_LAST) begin
              state    <= DONE;
              bus.busy <= 1'b0;
            end else begin
              cy <= cy + 7'd1;
            end
          end else begin
            cx <= cx + 8'd1;
          end
        end

        CLEAR: begin
          bus.x      <= cx;
          bus.y      <= cy;
          bus.colour <= '0;
          bus.plot   <= 1'b1;
          if (cx == SCR_X_LAST) begin
            cx <= '0;
            if (cy == SCR_Y_LAST) begin
              state    <= DONE;
              bus.busy <= 1'b0;
            end else begin
              cy <= cy + 7'd1;
            end
          end else begin
            cx <= cx + 8'd1;
          end
        end

        DONE: begin
          bus.done <= 1'b1;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_box_plot_ctrl.sv
// Directed bench for vga_box_plot_ctrl: box draws (normal, clipped, wrapped), full clear,
// request collisions, ignored mid-operation inputs and reset abort.
module tb_vga_box_plot_ctrl;

  logic clk = 1'b0;
  logic resetn;

  always #10 clk = ~clk;

  vga_box_plot_ctrl_if bus();

  vga_box_plot_ctrl dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0] cap_x[$];
  logic [6:0] cap_y[$];
  logic [2:0] cap_c[$];
  int         n_plot, first_c, last_c, done_c, busy_c;
  logic [7:0] dx;
  logic [6:0] dy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_org(input logic lx, input logic ly, input logic [6:0] v);
    @(negedge clk);
    bus.ld_x    = lx;
    bus.ld_y    = ly;
    bus.data_in = v;
    @(negedge clk);
    bus.ld_x = 1'b0;
    bus.ld_y = 1'b0;
  endtask

  task automatic request(input logic d, input logic c, input logic [2:0] col);
    @(negedge clk);
    bus.draw      = d;
    bus.clear     = c;
    bus.colour_in = col;
  endtask

  // Cycle c counts negedges after the request was driven; poke injects ld_x=50 plus a draw.
  task automatic collect(input string pfx, input int limit, input int poke);
    cap_x.delete();
    cap_y.delete();
    cap_c.delete();
    n_plot = 0; first_c = -1; last_c = -1; done_c = -1; busy_c = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (bus.plot) begin
        cap_x.push_back(bus.x);
        cap_y.push_back(bus.y);
        cap_c.push_back(bus.colour);
        n_plot++;
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      if (bus.busy) busy_c++;
      if (c == 1) begin
        bus.draw  = 1'b0;
        bus.clear = 1'b0;
      end
      if (poke > 0 && c == poke) begin
        bus.ld_x = 1'b1; bus.data_in = 7'd50; bus.draw = 1'b1;
      end else if (poke > 0 && c == poke + 1) begin
        bus.ld_x = 1'b0; bus.draw = 1'b0;
      end
      if (bus.done) begin
        done_c = c;
        dx = bus.x;
        dy = bus.y;
        break;
      end
    end
    chk({pfx, "_done_seen"}, 32'(done_c > 0), 32'd1);
  endtask

  function automatic int clear_errs();
    int e = 0;
    for (int i = 0; i < n_plot; i++)
      if (cap_x[i] !== 8'(i % 160) || cap_y[i] !== 7'(i / 160) || cap_c[i] !== 3'd0) e++;
    return e;
  endfunction

  initial begin
    logic [17:0] exp_pix;
    int cnt;

    resetn = 1'b0;
    bus.ld_x = 1'b0; bus.ld_y = 1'b0; bus.data_in = '0;
    bus.colour_in = '0; bus.draw = 1'b0; bus.clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done}, 32'd0);
    resetn = 1'b1;

    // Box at (10,20), colour 5
    load_org(1'b1, 1'b0, 7'd10);
    load_org(1'b0, 1'b1, 7'd20);
    request(1'b1, 1'b0, 3'd5);
    collect("t1", 40, 0);
    chk("t1_nplot", n_plot, 16);
    chk("t1_first", first_c, 2);
    chk("t1_last", last_c, 17);
    chk("t1_done", done_c, 18);
    chk("t1_busy", busy_c, 16);
    for (int i = 0; i < 16; i++) begin
      exp_pix = {8'(10 + i % 4), 7'(20 + i / 4), 3'd5};
      chk($sformatf("t1_pix%0d", i), {cap_x[i], cap_y[i], cap_c[i]}, 32'(exp_pix));
    end
    @(negedge clk);
    chk("t1_done_pulse", {bus.done, bus.busy}, 32'd0);

    // ld_x and a second draw mid-operation are dropped
    request(1'b1, 1'b0, 3'd3);
    collect("t5", 40, 5);
    chk("t5_nplot", n_plot, 16);
    chk("t5_done", done_c, 18);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.plot || bus.busy) cnt++;
    end
    chk("t5_no_rerun", cnt, 0);
    request(1'b1, 1'b0, 3'd1);
    collect("t5b", 40, 0);
    chk("t5_xorg_kept", {cap_x[0], cap_c[0]}, {8'd10, 3'd1});

    // Bottom edge clipping; both origins loaded in one cycle
    load_org(1'b1, 1'b1, 7'd118);
    request(1'b1, 1'b0, 3'd6);
    collect("t2", 40, 0);
    chk("t2_nplot", n_plot, 8);
    chk("t2_busy", busy_c, 16);
    chk("t2_done", done_c, 18);
    chk("t2_last", last_c, 9);
    for (int i = 0; i < 8; i++) begin
      exp_pix = {8'(118 + i % 4), 7'(118 + i / 4), 3'd6};
      chk($sformatf("t2_pix%0d", i), {cap_x[i], cap_y[i], cap_c[i]}, 32'(exp_pix));
    end
    chk("t2_hold", {dx, dy}, {8'd121, 7'd119});

    // y sum crosses 127: must clip, not wrap to the top rows
    load_org(1'b0, 1'b1, 7'd126);
    request(1'b1, 1'b0, 3'd2);
    collect("t2b", 40, 0);
    chk("t2b_nplot", n_plot, 0);
    chk("t2b_done", done_c, 18);
    chk("t2b_busy", busy_c, 16);
    chk("t2b_hold", {dx, dy}, {8'd121, 7'd119});

    // Full-screen clear
    request(1'b0, 1'b1, 3'd7);
    collect("t3", 20000, 0);
    chk("t3_nplot", n_plot, 19200);
    chk("t3_span", last_c - first_c + 1, 19200);
    chk("t3_first", first_c, 2);
    chk("t3_done", done_c, 19202);
    chk("t3_busy", busy_c, 19200);
    chk("t3_pix_errs", clear_errs(), 0);
    chk("t3_lastpix", {dx, dy}, {8'd159, 7'd119});
    @(negedge clk);
    chk("t3_idle", {bus.busy, bus.plot, bus.done}, 32'd0);

    // draw + clear together: clear wins
    request(1'b1, 1'b1, 3'd7);
    collect("t4", 20000, 0);
    chk("t4_nplot", n_plot, 19200);
    chk("t4_pix_errs", clear_errs(), 0);

    // Reset during the fifth pixel of a draw
    load_org(1'b1, 1'b0, 7'd30);
    load_org(1'b0, 1'b1, 7'd40);
    request(1'b1, 1'b0, 3'd6);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) bus.draw = 1'b0;
    end
    chk("t6_pix4", {bus.plot, bus.x, bus.y}, {1'b1, 8'd30, 7'd41});
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst_outs", {bus.x, bus.y, bus.colour, bus.plot, bus.busy, bus.done}, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.plot || bus.busy || bus.done) cnt++;
    end
    chk("t6_idle", cnt, 0);
    request(1'b1, 1'b0, 3'd2);
    collect("t6b", 40, 0);
    chk("t6_nplot", n_plot, 16);
    chk("t6_first_pix", {cap_x[0], cap_y[0], cap_c[0]}, {8'd0, 7'd0, 3'd2});
    chk("t6_last_pix", {cap_x[15], cap_y[15]}, {8'd3, 7'd3});

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
